// File: rtl/spi_host_initiator.sv
// Host-side SPI initiator for the PSEC5 peripheral: frames byte commands onto
// serial_in through a gated pin clock and captures serial_out readback.
module spi_host_initiator #(
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned RD_LATENCY = 2,
  localparam int unsigned BYTE_W = 8
) (
  input  logic              sclk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [BYTE_W-1:0] cmd_addr,
  input  logic [BYTE_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [BYTE_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              mosi,
  output logic              sclk_out_en,
  input  logic              miso
);

  localparam int unsigned BIT_W = 4;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 8;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(15);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(7);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT_RD,
    CAPTURE,
    GAP
  } state_e;

  typedef struct packed {
    logic              write;
    logic [BYTE_W-1:0] addr;
    logic [BYTE_W-1:0] data;
  } cmd_t;

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] cap_q, cap_d;
  logic [BYTE_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              en_q, mosi_q;
  logic              en_c, mosi_c;

  // Posedge state register
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      bit_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      cap_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    bit_d    = bit_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          cmd_d.write = cmd_write;
          cmd_d.addr  = cmd_addr;
          // Read frames clock out a zero data byte
          cmd_d.data  = cmd_write ? cmd_wdata : '0;
          bit_d       = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        bit_d = bit_q + BIT_W'(1);
        if (bit_q == BIT_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          if (cmd_q.write) begin
            state_d = GAP;
          end else if (RD_LATENCY == 0) begin
            state_d = CAPTURE;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPTURE: begin
        cap_d[idx_q] = miso;
        idx_d        = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          rdata_d  = cap_d;
          rvalid_d = 1'b1;
          cnt_d    = '0;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // Pin values for the next negedge: address then data, LSB first
  always_comb begin
    en_c   = 1'b0;
    mosi_c = 1'b0;
    if (state_q == SHIFT || state_q == WAIT_RD || state_q == CAPTURE) begin
      en_c = 1'b1;
    end
    if (state_q == SHIFT) begin
      mosi_c = bit_q[BIT_W-1] ? cmd_q.data[bit_q[IDX_W-1:0]]
                              : cmd_q.addr[bit_q[IDX_W-1:0]];
    end
  end

  // Negedge pin retiming keeps the gated clock glitch-free and mosi centred
  always_ff @(negedge sclk or negedge rstn) begin
    if (!rstn) begin
      en_q   <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      en_q   <= en_c;
      mosi_q <= mosi_c;
    end
  end

  assign cmd_ready   = ready_q;
  assign busy        = busy_q;
  assign rsp_valid   = rvalid_q;
  assign rsp_rdata   = rdata_q;
  assign mosi        = mosi_q;
  assign sclk_out_en = en_q;

endmodule

// File: tb/tb_spi_host_initiator.sv
// Bench for spi_host_initiator: directed commands, a pin-level peripheral model
// and queue-based checking of frames and read responses.
module tb_spi_host_initiator;

  localparam int GAP = 4;
  localparam int LAT = 2;

  typedef struct {
    logic [15:0] bits;
    int          edges;
    int          first;
  } frame_t;

  typedef struct {
    logic [7:0] data;
    int         at;
  } rsp_t;

  logic       sclk = 1'b0;
  logic       rstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       miso = 1'b0;
  logic       cmd_ready, rsp_valid, busy, mosi, sclk_out_en;
  logic [7:0] rsp_rdata;

  logic       v0 = 1'b0;
  logic [7:0] a0 = 8'h00;
  logic       miso0 = 1'b0;
  logic       rdy0, rv0, busy0, mosi0, en0;
  logic [7:0] rd0;

  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;
  frame_t     fq[$];
  rsp_t       rq[$];
  logic [7:0] regs [256];
  logic [7:0] trig_mask = 8'h00;
  int         inst_start_cnt = 0;
  int         pc = 0;
  int         pfirst = 0;
  logic [15:0] psh = 16'h0000;
  bit         abort = 1'b0;
  bit         go0 = 1'b0;
  int         n0 = 0;

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  spi_host_initiator #(.GAP_CYCLES(GAP), .RD_LATENCY(LAT)) u_dut (
    .sclk(sclk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .mosi(mosi), .sclk_out_en(sclk_out_en), .miso(miso)
  );

  spi_host_initiator #(.GAP_CYCLES(GAP), .RD_LATENCY(0)) u_dut_lat0 (
    .sclk(sclk), .rstn(rstn),
    .cmd_valid(v0), .cmd_ready(rdy0), .cmd_write(1'b0),
    .cmd_addr(a0), .cmd_wdata(8'h00),
    .rsp_valid(rv0), .rsp_rdata(rd0), .busy(busy0),
    .mosi(mosi0), .sclk_out_en(en0), .miso(miso0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Peripheral side: a stopped pin clock ends the frame; 16 edges commit a write
  task automatic frame_end();
    frame_t e;
    if (abort) begin
      abort = 1'b0;
      if (fq.size() != 0) fq.delete(0);
    end else if (fq.size() == 0) begin
      check("frame_unexpected", 32'(pc), 32'd0);
    end else begin
      e = fq.pop_front();
      check("frame_bits", 32'(psh), 32'(e.bits));
      check("frame_edges", pc, e.edges);
      check("frame_first_edge", pfirst, e.first);
    end
    if (pc == 16) begin
      regs[psh[7:0]] = psh[15:8];
      if (psh[7:0] == 8'd1) trig_mask = psh[15:8];
      if (psh[7:0] == 8'd2 && psh[8]) inst_start_cnt++;
    end
  endtask

  always @(posedge sclk) begin
    #1;
    if (sclk_out_en) begin
      if (pc == 0) pfirst = cyc;
      if (pc < 16) psh = {mosi, psh[15:1]};
      else check("mosi_idle", 32'(mosi), 32'd0);
      pc++;
    end else if (pc > 0) begin
      frame_end();
      pc = 0;
    end
  end

  always @(negedge sclk) begin
    logic [7:0] rb;
    rb = regs[psh[7:0]];
    if (pc >= 16 + LAT && pc < 24 + LAT) miso = rb[3'(pc - 16 - LAT)];
    else miso = 1'b0;
  end

  // Response monitor for the main instance
  always @(posedge sclk) begin
    rsp_t r;
    #1;
    if (rsp_valid) begin
      if (rq.size() == 0) begin
        check("rsp_spurious", 32'(rsp_valid), 32'd0);
      end else begin
        r = rq.pop_front();
        check("rsp_rdata", 32'(rsp_rdata), 32'(r.data));
        check("rsp_cycle", cyc, r.at);
      end
    end
  end

  // Zero-latency instance sees ones only in its eight capture cycles
  always @(negedge sclk) miso0 = go0 && (cyc >= n0 + 16) && (cyc <= n0 + 23);

  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, input bit hold, output int n);
    int guard;
    guard = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && guard < 200) begin
      @(negedge sclk);
      guard++;
    end
    if (!cmd_ready) begin
      check("handshake_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      n = cyc;
      return;
    end
    n = cyc + 1;
    fq.push_back('{{(w ? d : 8'h00), a}, (w ? 16 : 24 + LAT), n + 1});
    if (!w) rq.push_back('{exp_rd, n + 24 + LAT});
    @(posedge sclk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    @(negedge sclk);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 200) begin
      @(negedge sclk);
      guard++;
    end
    if (!cmd_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n1, n2, n3, n4, n5, guard;
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;
    regs[8'h10] = 8'h3C;

    repeat (3) @(negedge sclk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_sclk_out_en", 32'(sclk_out_en), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);

    // Command pending across reset release, then abandoned by a mid-frame reset
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'd1;
    cmd_wdata = 8'hC3;
    rstn      = 1'b1;
    fq.push_back('{16'hC301, 16, cyc + 2});
    @(posedge sclk);
    #1;
    check("accept_at_release", 32'(busy), 32'd1);
    cmd_valid = 1'b0;
    repeat (5) @(negedge sclk);
    #2;
    rstn  = 1'b0;
    abort = 1'b1;
    #1;
    check("midrst_sclk_out_en", 32'(sclk_out_en), 32'd0);
    check("midrst_mosi", 32'(mosi), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    repeat (2) @(negedge sclk);
    rstn = 1'b1;
    @(negedge sclk);
    check("postrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_no_commit", 32'(trig_mask), 32'd0);

    // Write A5 to addr 1 while scrambling the command inputs during the frame
    issue(1'b1, 8'd1, 8'hA5, 8'h00, 1'b0, n1);
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      cmd_addr  = 8'($urandom);
      cmd_wdata = 8'($urandom);
      @(negedge sclk);
      guard++;
    end
    check("ready_return_cycle", cyc, n1 + 16 + GAP);

    // Back-to-back with cmd_valid held: write, read, write
    issue(1'b1, 8'd2, 8'h03, 8'h00, 1'b1, n2);
    check("b2b_after_write", n2 - n1, 17 + GAP);
    check("trig_mask_a5", 32'(trig_mask), 32'hA5);
    issue(1'b0, 8'd2, 8'hEE, 8'h03, 1'b1, n3);
    check("b2b_write_to_read", n3 - n2, 17 + GAP);
    issue(1'b1, 8'd1, 8'h5A, 8'h00, 1'b0, n4);
    check("b2b_read_to_write", n4 - n3, 25 + LAT + GAP);
    wait_idle();

    // Standalone read of a preloaded register
    issue(1'b0, 8'h10, 8'h77, 8'h3C, 1'b0, n5);
    wait_idle();

    // Zero-latency read on the second instance
    check("lat0_ready", 32'(rdy0), 32'd1);
    v0  = 1'b1;
    a0  = 8'h44;
    n0  = cyc + 1;
    go0 = 1'b1;
    @(posedge sclk);
    #1;
    v0 = 1'b0;
    repeat (24) @(posedge sclk);
    #1;
    check("lat0_rsp_valid", 32'(rv0), 32'd1);
    check("lat0_rdata", 32'(rd0), 32'hFF);
    check("lat0_en_last_edge", 32'(en0), 32'd1);
    @(posedge sclk);
    #1;
    check("lat0_en_off", 32'(en0), 32'd0);
    check("lat0_rsp_pulse", 32'(rv0), 32'd0);

    repeat (40) @(negedge sclk);
    check("trig_mask_final", 32'(trig_mask), 32'h5A);
    check("inst_start_count", inst_start_cnt, 1);
    check("frames_pending", fq.size(), 0);
    check("rsp_pending", rq.size(), 0);
    check("final_idle_ready", 32'(cmd_ready), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
